decode_issue_reg: RTL
=====================

// Module: decode_issue_reg
// PURPOSE
//  Registered, parametrised decode stage between fetch and the AU/MUL/LSU execute units.
//  Decodes RV32IM, selects operands among regfile/NUM_FWD bypass sources, resolves branches/jumps.
//  Holds one micro-op in an output register with valid/ready backpressure.
//  Emits a one-cycle redirect for taken control flow; supports external flush.
// PARAMETERS
//  XLEN     32  datapath / PC width
//  NUM_FWD  7   number of bypass sources on fwd_data
//  SEL_W    3   forward-select width, >= clog2(NUM_FWD+1)
// PORTS
//  clk            in   1            rising-edge clock
//  rst            in   1            synchronous, active-high reset
//  in_valid       in   1            fetch presents in_instr/in_pc
//  in_ready       out  1            stage can accept this cycle
//  in_instr       in   32           instruction word
//  in_pc          in   XLEN         instruction PC
//  rf_data1       in   XLEN         regfile rs1 value
//  rf_data2       in   XLEN         regfile rs2 value
//  fwd_data       in   NUM_FWD*XLEN bypass values; source k in bits [k*XLEN +: XLEN]
//  fwd_sel1       in   SEL_W        rs1 source: 0=regfile, k=fwd source k-1
//  fwd_sel2       in   SEL_W        rs2 source, same encoding
//  flush          in   1            kill held micro-op and pending redirect
//  out_valid      out  1            micro-op register valid
//  out_ready      in   1            execute accepts micro-op
//  out_op1        out  XLEN         operand 1
//  out_op2        out  XLEN         operand 2
//  out_store_data out  XLEN         store data (rs2), 0 otherwise
//  out_reg_write  out  1            writes rd
//  out_write_mem  out  1            store
//  out_unit       out  3            one-hot {lsu,mul,au}; 000 = no unit
//  out_exec_type  out  5            unit op code (table below)
//  out_illegal    out  1            undecodable instruction
//  redirect_valid out  1            one-cycle pulse, fetch must jump
//  redirect_addr  out  XLEN         redirect target
// BEHAVIOUR
//  - Reset: all outputs 0. After reset deasserts, in_ready=1.
//  - in_ready = !out_valid | out_ready.
//  - Accept when in_valid & in_ready & !flush & !redirect_valid.
//  - Accepted micro-op appears on out_* the next cycle (latency 1).
//  - out_* held stable while out_valid & !out_ready.
//  - Operand mux: sel 0 -> rf_dataN; 1..NUM_FWD -> fwd slice sel-1; sel > NUM_FWD -> rf_dataN.
//  - AU codes (R/I): add0 addi1 sub2 and3 andi4 or5 ori6 xor7 xori8 sll9 slli10 srl11 srli12
//    sra13 srai14 slt15 slti16 sltu17 sltiu18 lui19 auipc20.
//  - MUL codes, funct7=0000001: mul0 mulh1 div4 divu5 rem6 remu7; other funct3 -> illegal.
//  - LSU codes: lb0 lh1 lw2 lbu3 lhu4 sb5 sh6 sw7.
//  - I-type/load: op2 = sign-extended imm. Store: op2 = S-imm. lui: op1 = U-imm, op2 = 0.
//  - auipc: op1 = pc, op2 = U-imm.
//  - Branch (beq/bne/blt/bge/bltu/bgeu): compare muxed rs1/rs2 in the accept cycle.
//    Micro-op unit = 000, reg_write = 0.
//  - jal: target pc+J-imm. jalr: target (rs1+I-imm)&~1.
//    Both: unit au, exec 0, op1 = pc, op2 = 4, reg_write = 1.
//  - Taken branch/jump: redirect_valid = 1 in the cycle out_valid rises, redirect_addr = target.
//    Cleared next cycle. Any in_valid during redirect_valid is dropped (wrong path).
//  - Unknown opcode/funct: out_illegal = 1, unit = 000, reg_write = write_mem = 0, op1 = op2 = 0.
//    Still issued.
//  - flush: out_valid <= 0, redirect_valid <= 0 next cycle.
//    flush beats a simultaneous accept and drain. flush & rst: rst wins.
//  - Simultaneous drain & accept (out_valid & out_ready & in_valid): new op replaces, no bubble.
//  - Arithmetic is XLEN-bit, wrap-around; signed compares use two's complement.
// TESTING
//  - rst 2 cycles -> out_valid=0, redirect_valid=0, in_ready=1.
//  - add x3,x1,x2, sel1=0, sel2=2, rf1=5, fwd src1=9 -> next cycle op1=5, op2=9, unit=001, exec=0.
//  - out_ready=0 for 3 cycles with second instr waiting -> outputs stable, in_ready=0.
//    Both ops issued in order, none lost.
//  - beq, rs1=rs2=7, pc=0x100, imm=0x20 -> redirect_valid pulse, addr=0x120.
//    in_valid in the pulse cycle dropped.
//  - jalr, rs1=0x203, imm=4, pc=0x40 -> redirect 0x206, op1=0x40, op2=4, reg_write=1.
//  - opcode 0x7F -> out_illegal=1. flush with in_valid same cycle -> out_valid=0 next cycle.

Source files
------------

// File: rtl/decode_issue_reg.sv
// Registered RV32IM decode/issue stage between fetch and the AU/MUL/LSU units.
// Decodes one instruction per cycle, picks operands from the regfile or a bypass
// source, resolves branches and jumps, and holds the resulting micro-op in an
// output register with valid/ready handshaking. Taken control flow produces a
// one-cycle redirect pulse aligned with the micro-op becoming valid.
module decode_issue_reg #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 7,
  parameter int SEL_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         rf_data1,
  input  logic [XLEN-1:0]         rf_data2,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic [SEL_W-1:0]        fwd_sel1,
  input  logic [SEL_W-1:0]        fwd_sel2,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_op1,
  output logic [XLEN-1:0]         out_op2,
  output logic [XLEN-1:0]         out_store_data,
  output logic                    out_reg_write,
  output logic                    out_write_mem,
  output logic [2:0]              out_unit,
  output logic [4:0]              out_exec_type,
  output logic                    out_illegal,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_addr
);

  localparam logic [2:0] UNIT_NONE = 3'b000;
  localparam logic [2:0] UNIT_AU   = 3'b001;
  localparam logic [2:0] UNIT_MUL  = 3'b010;
  localparam logic [2:0] UNIT_LSU  = 3'b100;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // Operand source select: 0 or out-of-range picks the regfile value.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [SEL_W-1:0]        sel,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD*XLEN-1:0] fwd
  );
    logic [XLEN-1:0] res;
    res = rf;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (sel == SEL_W'(k + 1)) res = fwd[k*XLEN +: XLEN];
    end
    return res;
  endfunction

  // Sign-extend a 32-bit immediate (already sign-filled) to the datapath width.
  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    logic signed [31:0] sv;
    sv = signed'(v);
    return XLEN'(sv);
  endfunction

  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] jalr_sum;
  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;

  assign rs1    = fwd_mux(fwd_sel1, rf_data1, fwd_data);
  assign rs2    = fwd_mux(fwd_sel2, rf_data2, fwd_data);
  assign rs1_s  = signed'(rs1);
  assign rs2_s  = signed'(rs2);
  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = sext({{20{in_instr[31]}}, in_instr[31:20]});
  assign imm_s  = sext({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
  assign imm_b  = sext({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0});
  assign imm_u  = sext({in_instr[31:12], 12'b0});
  assign imm_j  = sext({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0});
  assign jalr_sum = rs1 + imm_i;

  logic [2:0]      d_unit;
  logic [4:0]      d_exec;
  logic            d_rw;
  logic            d_wm;
  logic            d_ill;
  logic [XLEN-1:0] d_op1;
  logic [XLEN-1:0] d_op2;
  logic [XLEN-1:0] d_sd;
  logic            d_taken;
  logic [XLEN-1:0] d_target;

  // Combinational decode of the instruction currently presented by fetch.
  always_comb begin
    d_unit   = UNIT_NONE;
    d_exec   = 5'd0;
    d_rw     = 1'b0;
    d_wm     = 1'b0;
    d_ill    = 1'b0;
    d_op1    = '0;
    d_op2    = '0;
    d_sd     = '0;
    d_taken  = 1'b0;
    d_target = '0;
    unique case (opcode)
      OPC_OP: begin
        d_op1 = rs1;
        d_op2 = rs2;
        d_rw  = 1'b1;
        if (funct7 == F7_MUL) begin
          d_unit = UNIT_MUL;
          case (funct3)
            3'b000:  d_exec = 5'd0;
            3'b001:  d_exec = 5'd1;
            3'b100:  d_exec = 5'd4;
            3'b101:  d_exec = 5'd5;
            3'b110:  d_exec = 5'd6;
            3'b111:  d_exec = 5'd7;
            default: d_ill  = 1'b1;
          endcase
        end else if (funct7 == F7_BASE) begin
          d_unit = UNIT_AU;
          case (funct3)
            3'b000:  d_exec = 5'd0;
            3'b001:  d_exec = 5'd9;
            3'b010:  d_exec = 5'd15;
            3'b011:  d_exec = 5'd17;
            3'b100:  d_exec = 5'd7;
            3'b101:  d_exec = 5'd11;
            3'b110:  d_exec = 5'd5;
            default: d_exec = 5'd3;
          endcase
        end else if (funct7 == F7_ALT) begin
          d_unit = UNIT_AU;
          case (funct3)
            3'b000:  d_exec = 5'd2;
            3'b101:  d_exec = 5'd13;
            default: d_ill  = 1'b1;
          endcase
        end else begin
          d_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        d_op1  = rs1;
        d_op2  = imm_i;
        d_rw   = 1'b1;
        d_unit = UNIT_AU;
        case (funct3)
          3'b000: d_exec = 5'd1;
          3'b010: d_exec = 5'd16;
          3'b011: d_exec = 5'd18;
          3'b100: d_exec = 5'd8;
          3'b110: d_exec = 5'd6;
          3'b111: d_exec = 5'd4;
          3'b001: begin
            if (funct7 == F7_BASE) d_exec = 5'd10;
            else                   d_ill  = 1'b1;
          end
          default: begin
            if (funct7 == F7_BASE)     d_exec = 5'd12;
            else if (funct7 == F7_ALT) d_exec = 5'd14;
            else                       d_ill  = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        d_unit = UNIT_AU;
        d_exec = 5'd19;
        d_op1  = imm_u;
        d_rw   = 1'b1;
      end
      OPC_AUIPC: begin
        d_unit = UNIT_AU;
        d_exec = 5'd20;
        d_op1  = in_pc;
        d_op2  = imm_u;
        d_rw   = 1'b1;
      end
      OPC_LOAD: begin
        d_unit = UNIT_LSU;
        d_op1  = rs1;
        d_op2  = imm_i;
        d_rw   = 1'b1;
        case (funct3)
          3'b000:  d_exec = 5'd0;
          3'b001:  d_exec = 5'd1;
          3'b010:  d_exec = 5'd2;
          3'b100:  d_exec = 5'd3;
          3'b101:  d_exec = 5'd4;
          default: d_ill  = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d_unit = UNIT_LSU;
        d_op1  = rs1;
        d_op2  = imm_s;
        d_sd   = rs2;
        d_wm   = 1'b1;
        case (funct3)
          3'b000:  d_exec = 5'd5;
          3'b001:  d_exec = 5'd6;
          3'b010:  d_exec = 5'd7;
          default: d_ill  = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        d_op1    = rs1;
        d_op2    = rs2;
        d_target = in_pc + imm_b;
        case (funct3)
          3'b000:  d_taken = (rs1 == rs2);
          3'b001:  d_taken = (rs1 != rs2);
          3'b100:  d_taken = (rs1_s < rs2_s);
          3'b101:  d_taken = (rs1_s >= rs2_s);
          3'b110:  d_taken = (rs1 < rs2);
          3'b111:  d_taken = (rs1 >= rs2);
          default: d_ill   = 1'b1;
        endcase
      end
      OPC_JAL: begin
        d_unit   = UNIT_AU;
        d_op1    = in_pc;
        d_op2    = XLEN'(4);
        d_rw     = 1'b1;
        d_taken  = 1'b1;
        d_target = in_pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          d_unit   = UNIT_AU;
          d_op1    = in_pc;
          d_op2    = XLEN'(4);
          d_rw     = 1'b1;
          d_taken  = 1'b1;
          d_target = {jalr_sum[XLEN-1:1], 1'b0};
        end else begin
          d_ill = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
    // An undecodable instruction still issues, but as an inert marker.
    if (d_ill) begin
      d_unit   = UNIT_NONE;
      d_exec   = 5'd0;
      d_rw     = 1'b0;
      d_wm     = 1'b0;
      d_op1    = '0;
      d_op2    = '0;
      d_sd     = '0;
      d_taken  = 1'b0;
      d_target = '0;
    end
  end

  logic            vld_p1;
  logic            redir_vld_p1;
  logic [XLEN-1:0] redir_addr_p1;
  logic [XLEN-1:0] op1_p1;
  logic [XLEN-1:0] op2_p1;
  logic [XLEN-1:0] sd_p1;
  logic            rw_p1;
  logic            wm_p1;
  logic [2:0]      unit_p1;
  logic [4:0]      exec_p1;
  logic            ill_p1;
  logic            accept;

  assign in_ready = !rst && (!vld_p1 || out_ready);
  // Instructions arriving while a redirect is announced are on the wrong path.
  assign accept   = in_valid && in_ready && !flush && !redir_vld_p1;

  // ---- stage p1: micro-op register (control) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      redir_vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1       <= 1'b0;
      redir_vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1       <= 1'b1;
      redir_vld_p1 <= d_taken;
    end else begin
      if (out_ready) vld_p1 <= 1'b0;
      redir_vld_p1 <= 1'b0;
    end
  end

  // Micro-op payload loads only on accept so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      redir_addr_p1 <= '0;
      op1_p1        <= '0;
      op2_p1        <= '0;
      sd_p1         <= '0;
      rw_p1         <= 1'b0;
      wm_p1         <= 1'b0;
      unit_p1       <= UNIT_NONE;
      exec_p1       <= 5'd0;
      ill_p1        <= 1'b0;
    end else if (accept) begin
      redir_addr_p1 <= d_taken ? d_target : '0;
      op1_p1        <= d_op1;
      op2_p1        <= d_op2;
      sd_p1         <= d_sd;
      rw_p1         <= d_rw;
      wm_p1         <= d_wm;
      unit_p1       <= d_unit;
      exec_p1       <= d_exec;
      ill_p1        <= d_ill;
    end
  end

  assign out_valid      = vld_p1;
  assign out_op1        = op1_p1;
  assign out_op2        = op2_p1;
  assign out_store_data = sd_p1;
  assign out_reg_write  = rw_p1;
  assign out_write_mem  = wm_p1;
  assign out_unit       = unit_p1;
  assign out_exec_type  = exec_p1;
  assign out_illegal    = ill_p1;
  assign redirect_valid = redir_vld_p1;
  assign redirect_addr  = redir_addr_p1;

endmodule
